// File: rtl/cdu_pkg.sv
// cdu_pkg: shared types and helpers for the CDU
// read-counter stage and its per-channel slices.
package cdu_pkg;

  localparam logic DIR_PLUS  = 1'b0;
  localparam logic DIR_MINUS = 1'b1;

  typedef enum logic {
    S_IDLE,
    S_REQ
  } cdu_state_e;

  function automatic int chan_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Clip a sum into the signed w-bit range.
  function automatic int sat_add(
    input int sum,
    input int w
  );
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/cdu_read_channel.sv
// cdu_read_channel: one channel's angle register,
// signed pending-increment count and sticky overflow.
module cdu_read_channel
  import cdu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int PEND_W = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              step_i,
  input  logic              up_i,
  input  logic              dn_i,
  input  logic              ack_i,
  input  logic              ack_dir_i,
  input  logic              zero_i,
  output logic [WIDTH-1:0]  angle_o,
  output logic [PEND_W-1:0] pend_o,
  output logic              ovf_o
);

  logic [WIDTH-1:0]  angle_q, angle_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;

  int d;
  int a;
  int sum;
  int clip;

  always_comb begin
    d = 0;
    if (step_i && up_i && !dn_i) d = 1;
    else if (step_i && dn_i && !up_i) d = -1;

    // A granted PINC removes a +1 from pending, MINC a -1.
    a = 0;
    if (ack_i) a = (ack_dir_i == DIR_MINUS) ? 1 : -1;

    sum  = int'($signed(pend_q)) + d + a;
    clip = sat_add(sum, PEND_W);

    angle_d = angle_q + WIDTH'(d);
    pend_d  = PEND_W'(clip);
    ovf_d   = ovf_q | (clip != sum);

    if (zero_i) begin
      angle_d = '0;
      pend_d  = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      angle_q <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      angle_q <= angle_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign angle_o = angle_q;
  assign pend_o  = pend_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/cdu_read_counter.sv
// cdu_read_counter: N-channel angle integrator with
// round-robin, flow-controlled AGC increment requests.
module cdu_read_counter
  import cdu_pkg::*;
#(
  parameter  int NCHAN  = 5,
  parameter  int WIDTH  = 16,
  parameter  int PEND_W = 6,
  localparam int CW     = chan_w(NCHAN)
) (
  input  logic                   CLOCKH,
  input  logic                   rst,
  input  logic                   step_en,
  input  logic [NCHAN-1:0]       UPLVL,
  input  logic [NCHAN-1:0]       DNLVL,
  input  logic [NCHAN-1:0]       CCDUZ,
  output logic [NCHAN*WIDTH-1:0] angle,
  output logic                   inc_req,
  output logic                   inc_dir,
  output logic [CW-1:0]          inc_chan,
  input  logic                   inc_ack,
  output logic [NCHAN-1:0]       pend_ovf
);

  cdu_state_e state_q, state_d;
  logic [CW-1:0] rr_q, rr_d;
  logic [CW-1:0] chan_q, chan_d;
  logic          dir_q, dir_d;
  logic          cancel_q, cancel_d;

  logic [PEND_W-1:0] pend_w [NCHAN];
  logic [CW-1:0]     idx;
  logic              found;
  logic              ack_fire;

  // A cancelled request still completes, but moves nothing.
  assign ack_fire = (state_q == S_REQ) && inc_ack && !cancel_q;

  for (genvar g = 0; g < NCHAN; g++) begin : g_ch
    cdu_read_channel #(
      .WIDTH (WIDTH),
      .PEND_W(PEND_W)
    ) u_ch (
      .clk_i    (CLOCKH),
      .rst_i    (rst),
      .step_i   (step_en),
      .up_i     (UPLVL[g]),
      .dn_i     (DNLVL[g]),
      .ack_i    (ack_fire && (chan_q == CW'(g))),
      .ack_dir_i(dir_q),
      .zero_i   (CCDUZ[g]),
      .angle_o  (angle[g*WIDTH +: WIDTH]),
      .pend_o   (pend_w[g]),
      .ovf_o    (pend_ovf[g])
    );
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    chan_d   = chan_q;
    dir_d    = dir_q;
    cancel_d = cancel_q;
    found    = 1'b0;
    idx      = '0;
    unique case (state_q)
      S_IDLE: begin
        for (int k = 1; k <= NCHAN; k++) begin
          idx = CW'((int'(rr_q) + k) % NCHAN);
          if (!found && (pend_w[idx] != '0)
              && !CCDUZ[idx]) begin
            found  = 1'b1;
            chan_d = idx;
            dir_d  = pend_w[idx][PEND_W-1];
          end
        end
        if (found) begin
          state_d  = S_REQ;
          cancel_d = 1'b0;
        end
      end
      S_REQ: begin
        if (CCDUZ[chan_q]) cancel_d = 1'b1;
        if (inc_ack) begin
          state_d = S_IDLE;
          rr_d    = chan_q;
        end
      end
    endcase
  end

  always_ff @(posedge CLOCKH) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_q     <= CW'(NCHAN - 1);
      chan_q   <= '0;
      dir_q    <= DIR_PLUS;
      cancel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      chan_q   <= chan_d;
      dir_q    <= dir_d;
      cancel_q <= cancel_d;
    end
  end

  assign inc_req  = (state_q == S_REQ);
  assign inc_dir  = dir_q;
  assign inc_chan = chan_q;

endmodule

// File: tb/tb_cdu_read_counter.sv
// tb_cdu_read_counter: directed stimulus with a
// behavioural model compared every cycle.
module tb_cdu_read_counter;

  localparam int NCHAN  = 5;
  localparam int WIDTH  = 16;
  localparam int PEND_W = 6;
  localparam int CW     = 3;
  localparam int PMAX   = 31;
  localparam int PMIN   = -32;

  logic                   CLOCKH = 1'b0;
  logic                   rst;
  logic                   step_en;
  logic [NCHAN-1:0]       UPLVL, DNLVL, CCDUZ;
  logic [NCHAN*WIDTH-1:0] angle;
  logic                   inc_req, inc_dir, inc_ack;
  logic [CW-1:0]          inc_chan;
  logic [NCHAN-1:0]       pend_ovf;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  int ack_mode = 0;
  bit seen = 1'b0;

  int g_chan[$];
  int g_dir[$];

  int m_ang[NCHAN];
  int m_pend[NCHAN];
  bit [NCHAN-1:0] m_ovf;
  bit m_req, m_dir, m_cancel;
  int m_chan, m_rr;

  always #5 CLOCKH = ~CLOCKH;

  cdu_read_counter #(
    .NCHAN (NCHAN),
    .WIDTH (WIDTH),
    .PEND_W(PEND_W)
  ) dut (
    .CLOCKH  (CLOCKH),
    .rst     (rst),
    .step_en (step_en),
    .UPLVL   (UPLVL),
    .DNLVL   (DNLVL),
    .CCDUZ   (CCDUZ),
    .angle   (angle),
    .inc_req (inc_req),
    .inc_dir (inc_dir),
    .inc_chan(inc_chan),
    .inc_ack (inc_ack),
    .pend_ovf(pend_ovf)
  );

  task automatic check(input string name,
                       input longint got,
                       input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, got, exp);
    end
  endtask

  function automatic int ang(input int ch);
    return int'(angle[ch*WIDTH +: WIDTH]);
  endfunction

  // Model: counts as plain integers, arbiter as a
  // "next pending channel after the last one served" rule.
  always @(posedge CLOCKH) begin : model
    int po[NCHAN];
    int d, a, s, j;
    bit hit;
    if (rst) begin
      for (int i = 0; i < NCHAN; i++) begin
        m_ang[i]  = 0;
        m_pend[i] = 0;
      end
      m_ovf = '0;
      m_req = 0; m_dir = 0; m_cancel = 0;
      m_chan = 0; m_rr = NCHAN - 1;
    end else begin
      po = m_pend;
      for (int i = 0; i < NCHAN; i++) begin
        d = 0;
        if (step_en) begin
          if (UPLVL[i] && !DNLVL[i]) d = 1;
          else if (DNLVL[i] && !UPLVL[i]) d = -1;
        end
        a = 0;
        if (m_req && inc_ack && !m_cancel && m_chan == i)
          a = m_dir ? 1 : -1;
        if (CCDUZ[i]) begin
          m_ang[i] = 0; m_pend[i] = 0; m_ovf[i] = 0;
        end else begin
          m_ang[i] = (m_ang[i] + d + 65536) % 65536;
          s = po[i] + d + a;
          if (s > PMAX) begin
            m_pend[i] = PMAX; m_ovf[i] = 1;
          end else if (s < PMIN) begin
            m_pend[i] = PMIN; m_ovf[i] = 1;
          end else m_pend[i] = s;
        end
      end
      if (!m_req) begin
        hit = 0;
        for (int k = 1; k <= NCHAN; k++) begin
          j = (m_rr + k) % NCHAN;
          if (!hit && po[j] != 0 && !CCDUZ[j]) begin
            hit = 1; m_req = 1; m_chan = j;
            m_dir = (po[j] < 0); m_cancel = 0;
          end
        end
      end else begin
        if (CCDUZ[m_chan]) m_cancel = 1;
        if (inc_ack) begin
          m_req = 0; m_rr = m_chan;
        end
      end
    end
  end

  always @(posedge CLOCKH) begin
    if (!rst && inc_req === 1'b1 && inc_ack) begin
      g_chan.push_back(int'(inc_chan));
      g_dir.push_back(int'(inc_dir));
    end
  end

  // AGC responder: 0 never, 1 always, 2 one cycle late.
  always @(negedge CLOCKH) begin
    case (ack_mode)
      0: inc_ack = 1'b0;
      1: inc_ack = 1'b1;
      default: inc_ack = inc_req && seen;
    endcase
    seen = inc_req;
  end

  always @(negedge CLOCKH) begin
    if (chk_en) begin
      for (int i = 0; i < NCHAN; i++)
        check($sformatf("angle[%0d]", i), ang(i), m_ang[i]);
      check("inc_req", inc_req, m_req);
      check("inc_chan", inc_chan, m_chan);
      check("inc_dir", inc_dir, m_dir);
      check("pend_ovf", pend_ovf, m_ovf);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCKH);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic clr_log();
    g_chan.delete();
    g_dir.delete();
  endtask

  function automatic int count_g(input int ch, input int dr);
    int n = 0;
    foreach (g_chan[k])
      if (g_chan[k] == ch && g_dir[k] == dr) n++;
    return n;
  endfunction

  int exp_ord[6] = '{0, 2, 4, 0, 2, 4};

  initial begin
    rst = 1'b1; step_en = 0;
    UPLVL = '0; DNLVL = '0; CCDUZ = '0;
    inc_ack = 0;
    tick(1);
    do_reset();
    chk_en = 1'b1;
    check("rst_req", inc_req, 0);
    check("rst_angle", angle == '0, 1);
    check("rst_ovf", pend_ovf, 0);

    // Three up strobes on channel 0, delayed ack.
    ack_mode = 2; clr_log();
    UPLVL = 5'b00001;
    step_en = 1; tick(1); step_en = 0;
    check("t1_lat_n1", inc_req, 0);
    tick(1);
    check("t1_lat_n2", inc_req, 1);
    check("t1_chan", inc_chan, 0);
    step_en = 1; tick(1); step_en = 0; tick(1);
    step_en = 1; tick(1); step_en = 0;
    tick(20);
    check("t1_angle0", ang(0), 3);
    check("t1_grants", g_chan.size(), 3);
    check("t1_pinc0", count_g(0, 0), 3);
    check("t1_idle", inc_req, 0);

    // Zero channel 1 then one down step; both levels = hold.
    clr_log(); UPLVL = '0;
    CCDUZ = 5'b00010; tick(1); CCDUZ = '0;
    DNLVL = 5'b00010;
    step_en = 1; tick(1); step_en = 0;
    tick(8);
    check("t2_angle1", ang(1), 16'hFFFF);
    check("t2_grants", g_chan.size(), 1);
    check("t2_minc1", count_g(1, 1), 1);
    UPLVL = 5'b00010;
    step_en = 1; tick(1); step_en = 0;
    UPLVL = '0; DNLVL = '0;
    tick(4);
    check("t2_hold", ang(1), 16'hFFFF);
    check("t2_nogrant", g_chan.size(), 1);

    // Saturation on channel 2 with AGC stalled.
    do_reset(); ack_mode = 0; clr_log();
    UPLVL = 5'b00100;
    step_en = 1; tick(40); step_en = 0;
    UPLVL = '0;
    tick(2);
    check("t3_angle2", ang(2), 40);
    check("t3_ovf2", pend_ovf[2], 1);
    check("t3_req", inc_req, 1);
    check("t3_chan", inc_chan, 2);
    ack_mode = 2;
    tick(120);
    check("t3_pulses", count_g(2, 0), 31);
    check("t3_total", g_chan.size(), 31);
    check("t3_idle", inc_req, 0);
    check("t3_ovf_sticky", pend_ovf[2], 1);

    // Round robin over channels 0, 2, 4.
    do_reset(); ack_mode = 0;
    UPLVL = 5'b10101;
    step_en = 1; tick(2); step_en = 0;
    UPLVL = '0;
    clr_log(); ack_mode = 1;
    tick(20);
    check("t4_grants", g_chan.size(), 6);
    for (int k = 0; k < 6 && k < g_chan.size(); k++)
      check($sformatf("t4_order%0d", k), g_chan[k],
            exp_ord[k]);
    check("t4_pinc", count_g(0, 0) + count_g(2, 0)
          + count_g(4, 0), 6);

    // Zero channel 3 while its request is in flight.
    do_reset(); ack_mode = 0; clr_log();
    UPLVL = 5'b01000;
    step_en = 1; tick(2); step_en = 0;
    UPLVL = '0;
    tick(1);
    check("t5_req", inc_req, 1);
    check("t5_chan", inc_chan, 3);
    check("t5_angle_pre", ang(3), 2);
    CCDUZ = 5'b01000; tick(1); CCDUZ = '0;
    check("t5_angle0", ang(3), 0);
    check("t5_req_held", inc_req, 1);
    check("t5_ovf", pend_ovf[3], 0);
    ack_mode = 2;
    tick(10);
    check("t5_one_ack", g_chan.size(), 1);
    check("t5_no_more", inc_req, 0);

    // Reset while a request is up.
    do_reset(); ack_mode = 0;
    UPLVL = 5'b00010;
    step_en = 1; tick(1); step_en = 0;
    UPLVL = '0;
    tick(2);
    check("t6_req_up", inc_req, 1);
    rst = 1; tick(1); rst = 0;
    check("t6_req0", inc_req, 0);
    check("t6_chan0", inc_chan, 0);
    check("t6_dir0", inc_dir, 0);
    check("t6_angle0", angle == '0, 1);
    clr_log(); ack_mode = 2;
    UPLVL = 5'b00001;
    step_en = 1; tick(1); step_en = 0;
    UPLVL = '0;
    check("t6_lat_n1", inc_req, 0);
    tick(1);
    check("t6_lat_n2", inc_req, 1);
    check("t6_chan", inc_chan, 0);
    tick(6);
    check("t6_done", inc_req, 0);
    check("t6_grant", count_g(0, 0), 1);
    check("t6_ang", ang(0), 1);

    chk_en = 1'b0;
    tick(1);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
